ecc_dsa_uop_sequencer: RTL
==========================

Name: ecc_dsa_uop_sequencer

Overview:
- Program-counter and fetch/issue controller for the ECC DSA micro-op program ROM.
- On reset it runs the init subroutine at addresses 0..11, then waits in idle with the PC parked at ECC_NOP (12).
- A command from the ECC control register block selects one subroutine (keygen, sign, verify or DH shared key). The sequencer fetches each 21-bit instruction, presents it to the DSA datapath as a one-cycle uop, and stalls while the point-mul or HMAC-DRBG engine is busy.

Parameters:
- PROG_ADDR_W, 7, program ROM address width.
- INSTR_W, 21, instruction width: 9-bit opcode plus two 6-bit operand fields.
- OPCODE_W, 9, opcode field width: op_sel, wr_en, rd_en, pm_cmd[3:0], hmac_drbg_en, sca_en.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- zeroize  in  1  synchronous clear; same effect as reset
- cmd_valid_i  in  1  command request
- cmd_i  in  3  1=keygen, 2=sign, 3=verify, 4=shared key; any other value is invalid
- cmd_ready_o  out  1  high only in IDLE
- prog_rd_en_o  out  1  ROM read strobe
- prog_addr_o  out  PROG_ADDR_W  ROM address
- prog_instr_i  in  INSTR_W  ROM data, valid one cycle after prog_rd_en_o
- uop_valid_o  out  1  one-cycle instruction issue strobe
- uop_o  out  INSTR_W  issued instruction (registered)
- pm_busy_i  in  1  point-mul engine busy
- hmac_busy_i  in  1  HMAC-DRBG busy
- busy_o  out  1  high whenever state is not IDLE
- done_o  out  1  one-cycle pulse at the end of a command subroutine

Behaviour:
- Subroutine ranges, start..end inclusive:
  - init: 0..11
  - keygen: 14..26
  - sign: 28..42
  - verify: 44..67
  - shared key: 69..86
- States: START, FETCH, LATCH, ISSUE, ARM, WAIT, DONE, IDLE.
- Reset or zeroize:
  - state=START, pc=0, end_addr=11, is_init=1.
  - Outputs: cmd_ready_o=0, prog_rd_en_o=0, prog_addr_o=0, uop_valid_o=0, uop_o=0, done_o=0, busy_o=1.
  - Zeroize wins over every other event in the same cycle. Reset or zeroize mid-command aborts it: no done_o, and the init program is re-run.
- START -> FETCH after one cycle.
- FETCH: prog_rd_en_o=1, prog_addr_o=pc; -> LATCH.
- LATCH: capture prog_instr_i into uop_o; -> ISSUE.
- ISSUE: uop_valid_o=1 for exactly one cycle.
  - If opcode pm_cmd!=0 or hmac_drbg_en=1: -> ARM.
  - Otherwise: -> DONE if pc==end_addr, else pc<=pc+1 and -> FETCH.
- ARM: one cycle, busy inputs ignored. The engine must raise its busy in this cycle; -> WAIT.
- WAIT: hold while (pm_busy_i|hmac_busy_i). When both are low: -> DONE if pc==end_addr, else pc+1 and -> FETCH.
- DONE: pc<=12.
  - done_o=1 for one cycle if is_init=0; no done_o for the init program.
  - -> IDLE, and is_init<=0.
- IDLE: cmd_ready_o=1, busy_o=0.
  - cmd_valid_i with a valid cmd_i: load pc=start and end_addr=end for that command; -> FETCH.
  - An invalid cmd_i is ignored: no state change, no error output.
- Commands outside IDLE are not accepted (cmd_ready_o=0) and are dropped, not queued.
- Throughput:
  - Non-stalling instruction: 3 cycles (FETCH, LATCH, ISSUE).
  - Stalling instruction: 4 cycles plus the busy duration.
  - Command accept to first uop_valid_o: 3 cycles.
- pc never wraps: it only increments up to end_addr. The operand fields are passed through unmodified.
- uop_o holds its last value outside ISSUE; consumers qualify it with uop_valid_o.

Test Plan:
- Reset release, ROM filled with NOP (all-zero) instructions -> prog_addr_o steps 0..11, 12 uop_valid_o pulses spaced 3 cycles apart, no done_o, then cmd_ready_o=1 and busy_o=0.
- Keygen (cmd_i=1) with all-zero opcodes -> fetches 14..26, 13 uops, one done_o pulse 1 cycle after the last ISSUE, IDLE with pc=12.
- Sign, address 30 holds pm_cmd=4'b0010, pm_busy_i high for 50 cycles from ARM -> no fetch of 31 until the cycle after pm_busy_i falls; 15 uops total, done_o once.
- Verify running, cmd_valid_i=1 with cmd_i=4 -> cmd_ready_o=0, request ignored; verify completes at 67 and no shared-key run follows.
- IDLE, cmd_valid_i=1 with cmd_i=5 or 0 -> no prog_rd_en_o, stays IDLE, cmd_ready_o stays 1.
- Shared key (cmd_i=4), zeroize pulsed while pc=75 -> next cycle uop_valid_o=0 and busy_o=1, init re-runs from address 0, done_o never asserts.

Source files
------------

// File: rtl/ecc_dsa_uop_sequencer.sv
// ECC DSA micro-op sequencer: walks the program ROM one instruction at a time,
// issues each as a one-cycle uop and stalls while point-mul or HMAC-DRBG is busy.
module ecc_dsa_uop_sequencer #(
  parameter int PROG_ADDR_W = 7,
  parameter int INSTR_W     = 21,
  parameter int OPCODE_W    = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   zeroize,
  input  logic                   cmd_valid_i,
  input  logic [2:0]             cmd_i,
  output logic                   cmd_ready_o,
  output logic                   prog_rd_en_o,
  output logic [PROG_ADDR_W-1:0] prog_addr_o,
  input  logic [INSTR_W-1:0]     prog_instr_i,
  output logic                   uop_valid_o,
  output logic [INSTR_W-1:0]     uop_o,
  input  logic                   pm_busy_i,
  input  logic                   hmac_busy_i,
  output logic                   busy_o,
  output logic                   done_o
);

  // state | meaning
  // START | after reset/zeroize, before the init program
  // FETCH | ROM read of pc
  // LATCH | ROM data captured into uop register
  // ISSUE | uop_valid_o strobe, decide stall
  // ARM   | engine raises its busy, inputs ignored
  // WAIT  | hold until both engines idle
  // DONE  | end of subroutine, pc parked at NOP
  // IDLE  | ready for a command
  typedef enum logic [2:0] {
    S_START, S_FETCH, S_LATCH, S_ISSUE, S_ARM, S_WAIT, S_DONE, S_IDLE
  } state_t;

  typedef logic [PROG_ADDR_W-1:0] addr_t;

  localparam addr_t INIT_END = addr_t'(11);
  localparam addr_t NOP_ADDR = addr_t'(12);
  localparam int    OP_LSB   = INSTR_W - OPCODE_W;

  state_t state, state_nxt;
  addr_t  pc, end_addr;
  addr_t  cmd_start, cmd_end;
  logic   cmd_hit;
  logic   is_init;
  logic   [INSTR_W-1:0] uop_q;
  logic   stall_op, engine_busy, last_instr;

  assign stall_op    = (uop_q[OP_LSB+2 +: 4] != 4'd0) | uop_q[OP_LSB+1];
  assign engine_busy = pm_busy_i | hmac_busy_i;
  assign last_instr  = (pc == end_addr);

  always_comb begin
    cmd_hit   = 1'b1;
    cmd_start = '0;
    cmd_end   = '0;
    case (cmd_i)
      3'd1: begin cmd_start = addr_t'(14); cmd_end = addr_t'(26); end
      3'd2: begin cmd_start = addr_t'(28); cmd_end = addr_t'(42); end
      3'd3: begin cmd_start = addr_t'(44); cmd_end = addr_t'(67); end
      3'd4: begin cmd_start = addr_t'(69); cmd_end = addr_t'(86); end
      default: cmd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        state <= S_START;
    else if (zeroize) state <= S_START;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (stall_op)        state_nxt = S_ARM;
        else if (last_instr) state_nxt = S_DONE;
        else                 state_nxt = S_FETCH;
      end
      S_ARM:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (!engine_busy) state_nxt = last_instr ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_IDLE:  if (cmd_valid_i && cmd_hit) state_nxt = S_FETCH;
      default: state_nxt = S_START;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    prog_rd_en_o = 1'b0;
    uop_valid_o  = 1'b0;
    done_o       = 1'b0;
    busy_o       = 1'b1;
    case (state)
      S_FETCH: prog_rd_en_o = 1'b1;
      S_ISSUE: uop_valid_o  = 1'b1;
      S_DONE:  done_o       = ~is_init;
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      default: ;
    endcase
  end

  // pc only advances toward end_addr, so it can never wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      end_addr <= INIT_END;
      is_init  <= 1'b1;
      uop_q    <= '0;
    end else if (zeroize) begin
      pc       <= '0;
      end_addr <= INIT_END;
      is_init  <= 1'b1;
      uop_q    <= '0;
    end else begin
      case (state)
        S_LATCH: uop_q <= prog_instr_i;
        S_ISSUE: if (!stall_op && !last_instr) pc <= pc + addr_t'(1);
        S_WAIT:  if (!engine_busy && !last_instr) pc <= pc + addr_t'(1);
        S_DONE: begin
          pc      <= NOP_ADDR;
          is_init <= 1'b0;
        end
        S_IDLE: begin
          if (cmd_valid_i && cmd_hit) begin
            pc       <= cmd_start;
            end_addr <= cmd_end;
          end
        end
        default: ;
      endcase
    end
  end

  assign prog_addr_o = pc;
  assign uop_o       = uop_q;

endmodule
